// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// The HALT state is only reachable when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_8000;
    localparam logic [31:0] INST_BYTES       = 32'd4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect arbiter: CSR redirects win over jump/branch redirects.
// Reports the selected target raw, word-aligned, and whether it was misaligned.
module fetch_redirect_sel (
    input  logic        csr_valid,
    input  logic [31:0] csr_pc,
    input  logic        jump_valid,
    input  logic [31:0] jump_pc,
    output logic        taken,
    output logic        is_csr,
    output logic [31:0] target,
    output logic [31:0] target_aligned,
    output logic        misaligned
);

    always_comb begin
        taken          = csr_valid || jump_valid;
        is_csr         = csr_valid;
        target         = csr_valid ? csr_pc : jump_pc;
        target_aligned = {target[31:2], 2'b00};
        misaligned     = taken && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, one-entry decode buffer,
// stale-response dropping after redirects. FETCH_MISALIGN_TRAP_EN enables misalign traps + HALT.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_csr_valid,
    input  logic [31:0] redirect_csr_pc,
    input  logic        redirect_jump_valid,
    input  logic [31:0] redirect_jump_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_data_q, inst_data_d;
    logic [31:0]  inst_pc_q, inst_pc_d;

    logic         rd_taken;
    logic         rd_is_csr;
    logic [31:0]  rd_target;
    logic [31:0]  rd_target_aligned;
    logic         rd_misaligned;
    logic         req_fire;

    fetch_redirect_sel u_redirect_sel (
        .csr_valid      (redirect_csr_valid),
        .csr_pc         (redirect_csr_pc),
        .jump_valid     (redirect_jump_valid),
        .jump_pc        (redirect_jump_pc),
        .taken          (rd_taken),
        .is_csr         (rd_is_csr),
        .target         (rd_target),
        .target_aligned (rd_target_aligned),
        .misaligned     (rd_misaligned)
    );

    // Request valid depends only on registered state and inst_ready, never on redirects.
    assign imem_req_valid = (state_q == REQ) && (!inst_valid_q || inst_ready);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    logic        halt_pending_q, halt_pending_d;
    logic        outstanding_next;
`else
    logic        unused_sel;
    assign unused_sel = ^{rd_is_csr, rd_target, rd_misaligned};
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_d           = 1'b0;
        trap_addr_d      = trap_addr_q;
        halt_pending_d   = halt_pending_q;
        outstanding_next = 1'b0;
`endif

        if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    state_d = rd_taken ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (!rd_taken) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = imem_rsp_data;
                        inst_pc_d    = pc_q;
                        pc_d         = pc_q + INST_BYTES;
                    end
                    state_d = REQ;
                end else if (rd_taken) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // A request may still be in flight when we halt; remember it so the exit path drops it.
        outstanding_next = ((state_q == REQ) && req_fire) ||
                           (((state_q == WAIT) || (state_q == DROP)) && !imem_rsp_valid);
        if (state_q == HALT) begin
            state_d = HALT;
            if (imem_rsp_valid) begin
                halt_pending_d = 1'b0;
            end
            if (rd_taken && rd_is_csr) begin
                if (rd_misaligned) begin
                    trap_d      = 1'b1;
                    trap_addr_d = rd_target;
                end else begin
                    pc_d           = rd_target;
                    state_d        = (halt_pending_q && !imem_rsp_valid) ? DROP : REQ;
                    halt_pending_d = 1'b0;
                end
            end
        end else if (rd_taken) begin
            inst_valid_d = 1'b0;
            if (rd_misaligned) begin
                trap_d         = 1'b1;
                trap_addr_d    = rd_target;
                state_d        = HALT;
                halt_pending_d = outstanding_next;
            end else begin
                pc_d = rd_target;
            end
        end
`else
        if (rd_taken) begin
            pc_d         = rd_target_aligned;
            inst_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_data_q  <= 32'd0;
            inst_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_q         <= 1'b0;
            trap_addr_q    <= 32'd0;
            halt_pending_q <= 1'b0;
        end else begin
            trap_q         <= trap_d;
            trap_addr_q    <= trap_addr_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    assign misalign_trap = trap_q;
    assign misalign_addr = trap_addr_q;
`else
    assign misalign_trap = 1'b0;
    assign misalign_addr = 32'd0;
`endif

    assign inst_valid = inst_valid_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule
